tile_addr_gen: RTL and testbench
================================

Name: tile_addr_gen

Overview:
- Parametrised tile-to-character-RAM address generator for the text-overlay path.
- Maps a tile coordinate (column T_h, row T_v) from the video timing logic to a linear character-buffer address: BASE + row*COLS + column.
- Adds vertical scroll with row wrap-around, tear-free scroll update at frame start, out-of-range detection, and a valid-qualified 2-stage pipeline.
- Sits between the tile-counter logic and the character RAM read port.

Parameters:
- COLS, 39, tiles per text row (1..2^H_W).
- ROWS, 30, tile rows per screen (1..2^V_W).
- H_W, 6, width of T_h.
- V_W, 6, width of T_v and scroll value.
- ADDR_W, 11, address width; COLS*ROWS+BASE must fit in 2^ADDR_W.
- BASE, 0, buffer base address added to every address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  qualifies T_h/T_v this cycle.
- T_h  in  H_W  tile column.
- T_v  in  V_W  tile row (screen-relative).
- frame_start  in  1  one-cycle pulse at frame start; applies pending scroll.
- scroll_wr  in  1  write strobe for scroll_val.
- scroll_val  in  V_W  requested row scroll offset.
- out_valid  out  1  addr/oob valid.
- addr  out  ADDR_W  character-buffer address.
- oob  out  1  input coordinate out of range.
- scroll_err  out  1  sticky: a scroll write was rejected.

Behaviour:
- Reset (async, active-high): out_valid=0, addr=0, oob=0, scroll_err=0; active and pending scroll =0; all pipeline valids cleared. Reset mid-operation discards in-flight data; the first out_valid after release needs a new in_valid.
- Scroll registers:
  - scroll_wr with scroll_val<ROWS loads pending.
  - scroll_val>=ROWS is ignored and sets scroll_err. Only rst clears scroll_err.
  - frame_start copies pending into active.
  - scroll_wr and frame_start in the same cycle: the written value goes to both pending and active (write wins). If that write is rejected, active takes the old pending value.
  - Active scroll changes only on frame_start.
- Stage 1, on clk when in_valid:
  - oob1 = (T_h>=COLS) | (T_v>=ROWS).
  - row1 = T_v+scroll_active, width V_W+1. If row1>=ROWS, subtract ROWS (single subtract is sufficient because both operands are <ROWS).
  - col1 = T_h.
  - v1 <= in_valid.
  - Active scroll is sampled in the same cycle as in_valid.
- Stage 2:
  - addr <= oob1 ? 0 : BASE+row1*COLS+col1, truncated to ADDR_W.
  - oob <= oob1; out_valid <= v1.
  - The multiplier is by a constant and must synthesise without a DSP-dependent construct.
- Latency: exactly 2 cycles from in_valid to out_valid. Throughput is 1 coordinate per cycle with no bubbles.
- Output hold: addr/oob hold their last values while out_valid=0. No backpressure.
- in_valid=0: the stage registers hold their data; only the valid bits propagate.

Test Plan:
- Reset, then in_valid with T_v=2, T_h=5, scroll 0 (defaults) -> 2 cycles later out_valid=1, addr=83, oob=0; next cycle out_valid=0, addr stays 83.
- Stream T_v=0 and T_h=0..38 back-to-back, then T_v=29, T_h=38 -> addr 0..38 on consecutive cycles, then 1169, with no gaps in out_valid.
- scroll_wr with scroll_val=3, then T_v=28, T_h=4 before frame_start -> addr=1096. After a frame_start pulse, the same input gives row 1 -> addr=43. Same-cycle scroll_wr with 5 and frame_start, then T_v=0, T_h=0 -> addr=195.
- T_h=39, T_v=0 and T_h=0, T_v=30 -> oob=1, addr=0. scroll_wr with scroll_val=30 -> scroll_err=1, active scroll unchanged, and scroll_err stays 1 through later valid writes.
- Assert rst one cycle after in_valid (data in flight) -> out_valid never rises for that input. After release: addr=0, scroll cleared, a new input with T_v=1, T_h=1 gives addr=40.
- Re-parametrise with COLS=80, ROWS=25, H_W=7, V_W=5, ADDR_W=12, BASE=1024 and input T_v=24, T_h=79 -> addr=3023.

Source files
------------

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - tile coordinate to character-buffer address generator
// Two-stage valid-qualified pipeline with frame-synchronous vertical scroll.
module tile_addr_gen #(
  parameter int COLS   = 39,
  parameter int ROWS   = 30,
  parameter int H_W    = 6,
  parameter int V_W    = 6,
  parameter int ADDR_W = 11,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [H_W-1:0]    T_h,
  input  logic [V_W-1:0]    T_v,
  input  logic              frame_start,
  input  logic              scroll_wr,
  input  logic [V_W-1:0]    scroll_val,
  output logic              out_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              oob,
  output logic              scroll_err
);

  localparam logic [H_W:0]        COLS_H = (H_W+1)'(COLS);
  localparam logic [V_W:0]        ROWS_V = (V_W+1)'(ROWS);
  localparam logic [31:0]         COLS_K = 32'(COLS);
  localparam logic [ADDR_W-1:0]   BASE_A = ADDR_W'(BASE);

  logic [V_W-1:0]    scroll_pend;
  logic [V_W-1:0]    scroll_act;
  logic              wr_ok;
  logic [V_W:0]      row_sum;
  logic [V_W-1:0]    row_wrap;
  logic              oob_next;
  logic              v1;
  logic              oob1;
  logic [V_W-1:0]    row1;
  logic [H_W-1:0]    col1;
  logic [ADDR_W-1:0] addr_next;

  // Constant multiply as a shift-and-add over the set bits of COLS.
  function automatic logic [ADDR_W-1:0] mul_cols(input logic [V_W-1:0] r);
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] sh;
    acc = '0;
    sh  = ADDR_W'(r);
    for (int i = 0; i < 32; i++) begin
      if (COLS_K[i]) acc = acc + sh;
      sh = sh << 1;
    end
    return acc;
  endfunction

  always_comb begin
    wr_ok     = scroll_wr && ({1'b0, scroll_val} < ROWS_V);
    row_sum   = {1'b0, T_v} + {1'b0, scroll_act};
    row_wrap  = V_W'((row_sum >= ROWS_V) ? row_sum - ROWS_V : row_sum);
    oob_next  = ({1'b0, T_h} >= COLS_H) || ({1'b0, T_v} >= ROWS_V);
    addr_next = BASE_A + mul_cols(row1) + ADDR_W'(col1);
  end

  // A write in the same cycle as frame_start bypasses pending straight into active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_pend <= '0;
      scroll_act  <= '0;
      scroll_err  <= 1'b0;
    end else begin
      if (wr_ok) scroll_pend <= scroll_val;
      if (frame_start) scroll_act <= wr_ok ? scroll_val : scroll_pend;
      if (scroll_wr && !wr_ok) scroll_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      oob1 <= 1'b0;
      row1 <= '0;
      col1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        oob1 <= oob_next;
        row1 <= row_wrap;
        col1 <= T_h;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      addr      <= '0;
      oob       <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        addr <= oob1 ? '0 : addr_next;
        oob  <= oob1;
      end
    end
  end

endmodule

// File: tb/tb_tile_addr_gen.sv
// tb/tb_tile_addr_gen.sv - directed vector bench for tile_addr_gen
module tb_tile_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  T_h;
  logic [5:0]  T_v;
  logic        frame_start;
  logic        scroll_wr;
  logic [5:0]  scroll_val;
  logic        out_valid;
  logic [10:0] addr;
  logic        oob;
  logic        scroll_err;

  logic        in_valid2;
  logic [6:0]  T_h2;
  logic [4:0]  T_v2;
  logic        out_valid2;
  logic [11:0] addr2;
  logic        oob2;
  logic        scroll_err2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tile_addr_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .T_h(T_h), .T_v(T_v),
    .frame_start(frame_start), .scroll_wr(scroll_wr), .scroll_val(scroll_val),
    .out_valid(out_valid), .addr(addr), .oob(oob), .scroll_err(scroll_err)
  );

  tile_addr_gen #(
    .COLS(80), .ROWS(25), .H_W(7), .V_W(5), .ADDR_W(12), .BASE(1024)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .T_h(T_h2), .T_v(T_v2),
    .frame_start(1'b0), .scroll_wr(1'b0), .scroll_val(5'd0),
    .out_valid(out_valid2), .addr(addr2), .oob(oob2), .scroll_err(scroll_err2)
  );

  typedef struct {
    logic [6:0]  th;
    logic [5:0]  tv;
    logic [11:0] exp_addr;
    logic        exp_oob;
  } vec_t;

  vec_t vecs[$];
  vec_t vecs2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Single isolated coordinate; checked at the output two cycles later.
  task automatic single(input string name, input logic [5:0] th, input logic [5:0] tv,
                        input logic [10:0] ea, input logic eo);
    @(posedge clk); #1;
    T_h = th; T_v = tv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check(name, 32'({out_valid, oob, addr}), 32'({1'b1, eo, ea}));
  endtask

  task automatic scroll_cmd(input logic wr, input logic [5:0] val, input logic fs);
    @(posedge clk); #1;
    scroll_wr = wr; scroll_val = val; frame_start = fs;
    @(posedge clk); #1;
    scroll_wr = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; T_h = '0; T_v = '0;
    frame_start = 1'b0; scroll_wr = 1'b0; scroll_val = '0;
    in_valid2 = 1'b0; T_h2 = '0; T_v2 = '0;

    for (int h = 0; h < 39; h++)
      vecs.push_back('{th: 7'(h), tv: 6'd0, exp_addr: 12'(h), exp_oob: 1'b0});
    vecs.push_back('{th: 7'd38, tv: 6'd29, exp_addr: 12'd1169, exp_oob: 1'b0});
    vecs.push_back('{th: 7'd39, tv: 6'd0,  exp_addr: 12'd0,    exp_oob: 1'b1});
    vecs.push_back('{th: 7'd0,  tv: 6'd30, exp_addr: 12'd0,    exp_oob: 1'b1});
    vecs.push_back('{th: 7'd7,  tv: 6'd3,  exp_addr: 12'd124,  exp_oob: 1'b0});

    vecs2.push_back('{th: 7'd79, tv: 6'd24, exp_addr: 12'd3023, exp_oob: 1'b0});
    vecs2.push_back('{th: 7'd0,  tv: 6'd0,  exp_addr: 12'd1024, exp_oob: 1'b0});
    vecs2.push_back('{th: 7'd80, tv: 6'd0,  exp_addr: 12'd0,    exp_oob: 1'b1});
    vecs2.push_back('{th: 7'd1,  tv: 6'd25, exp_addr: 12'd0,    exp_oob: 1'b1});
    vecs2.push_back('{th: 7'd10, tv: 6'd1,  exp_addr: 12'd1114, exp_oob: 1'b0});

    repeat (2) @(posedge clk); #1;
    check("reset", 32'({out_valid, oob, scroll_err, addr}), 32'd0);
    rst = 1'b0;

    single("first", 6'd5, 6'd2, 11'd83, 1'b0);
    @(posedge clk); #1;
    check("hold", 32'({out_valid, addr}), 32'({1'b0, 11'd83}));

    // Back-to-back stream: vector i appears at the output two cycles after issue.
    for (int s = 0; s < vecs.size() + 2; s++) begin
      @(posedge clk); #1;
      if (s >= 2)
        check($sformatf("stream[%0d]", s - 2), 32'({out_valid, oob, addr}),
              32'({1'b1, vecs[s-2].exp_oob, vecs[s-2].exp_addr[10:0]}));
      if (s < vecs.size()) begin
        T_h = vecs[s].th[5:0]; T_v = vecs[s].tv; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("stream_end", 32'({out_valid, addr}), 32'({1'b0, 11'd124}));

    scroll_cmd(1'b1, 6'd3, 1'b0);
    single("pending_only", 6'd4, 6'd28, 11'd1096, 1'b0);
    scroll_cmd(1'b0, 6'd0, 1'b1);
    single("scroll_wrap", 6'd4, 6'd28, 11'd43, 1'b0);
    scroll_cmd(1'b1, 6'd5, 1'b1);
    single("write_wins", 6'd0, 6'd0, 11'd195, 1'b0);
    check("err_clear", 32'(scroll_err), 32'd0);
    scroll_cmd(1'b1, 6'd30, 1'b1);
    check("err_set", 32'(scroll_err), 32'd1);
    single("reject_keeps", 6'd0, 6'd0, 11'd195, 1'b0);
    scroll_cmd(1'b1, 6'd2, 1'b0);
    check("err_sticky", 32'(scroll_err), 32'd1);

    @(posedge clk); #1;
    T_h = 6'd1; T_v = 6'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_async", 32'({out_valid, addr}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flushed", 32'(seen), 32'd0);
    check("rst_state", 32'({scroll_err, oob, addr}), 32'd0);
    single("after_rst", 6'd1, 6'd1, 11'd40, 1'b0);

    for (int s = 0; s < vecs2.size() + 2; s++) begin
      @(posedge clk); #1;
      if (s >= 2)
        check($sformatf("param[%0d]", s - 2), 32'({out_valid2, oob2, addr2}),
              32'({1'b1, vecs2[s-2].exp_oob, vecs2[s-2].exp_addr}));
      if (s < vecs2.size()) begin
        T_h2 = vecs2[s].th; T_v2 = vecs2[s].tv[4:0]; in_valid2 = 1'b1;
      end else begin
        in_valid2 = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
